// File: rtl/fetch_burst_controller.sv
// AXI4 read-channel instruction-fetch controller: issues block-aligned INCR bursts,
// tracks several outstanding requests and unpacks each R beat into {instr, pc} slots.
module fetch_burst_controller #(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned BURST_LEN       = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [31:0]                 araddr,
    output logic                        arvalid,
    input  logic                        arready,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    input  logic                        rvalid,
    output logic                        rready,
    input  logic [DATA_W-1:0]           rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        jump,
    input  logic [31:0]                 jump_addr,
    input  logic                        fifo_full,
    output logic                        write_fifo,
    output logic [64*(DATA_W/32)-1:0]   fetch_instr_pc,
    output logic [DATA_W/32-1:0]        slot_valid,
    output logic                        fetch_err
);

    localparam int unsigned NSLOT   = DATA_W / 32;
    localparam int unsigned BEAT_B  = DATA_W / 8;
    localparam int unsigned OFF_W   = $clog2(BEAT_B);
    localparam int unsigned BLOCK_B = BURST_LEN * BEAT_B;
    localparam int unsigned IDX_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [31:0] BEAT_MASK  = 32'(BEAT_B - 1);
    localparam logic [31:0] BLOCK_MASK = 32'(BLOCK_B - 1);

    typedef struct packed {
        logic [31:0]      addr;
        logic [NSLOT-1:0] mask;
    } req_t;

    req_t             req_q [MAX_OUTSTANDING];
    req_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [IDX_W-1:0] beat_cnt;
    logic [31:0]      pc;
    logic [31:0]      src_pc;
    logic [31:0]      beat_addr;
    logic [NSLOT-1:0] ar_mask;
    logic             q_empty;
    logic             ar_fire;
    logic             ar_hold;
    logic             ar_load;
    logic             r_fire;
    logic             r_last_fire;

    // Beats remaining to the end of the fetch block, so a burst never crosses it.
    function automatic logic [7:0] calc_arlen(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a & BLOCK_MASK) >> OFF_W;
        return 8'(32'(BURST_LEN - 1) - idx);
    endfunction

    function automatic logic [NSLOT-1:0] calc_mask(input logic [31:0] a);
        logic [31:0]      first;
        logic [NSLOT-1:0] m;
        first = (a & BEAT_MASK) >> 2;
        for (int i = 0; i < NSLOT; i++) begin
            m[i] = (32'(i) >= first);
        end
        return m;
    endfunction

    function automatic logic [31:0] next_block(input logic [31:0] a);
        return (a & ~BLOCK_MASK) + 32'(BLOCK_B);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign arsize  = 3'(OFF_W);
    assign arburst = 2'b01;

    // NOTE: every signal gets a default at the top of a combinational block so no path
    // leaves it unassigned, which is what would otherwise infer a latch.
    always_comb begin
        q_empty         = (outstanding == '0);
        head            = req_q[rd_ptr];
        rready          = (drop_cnt != '0) || q_empty || !fifo_full;
        r_fire          = rvalid && rready && !q_empty;
        r_last_fire     = r_fire && rlast;
        ar_fire         = arvalid && arready;
        ar_hold         = arvalid && !arready;
        outstanding_nxt = outstanding + CNT_W'(ar_fire) - CNT_W'(r_last_fire);
        ar_load         = !ar_hold && (outstanding_nxt < CNT_W'(MAX_OUTSTANDING));
        src_pc          = jump ? jump_addr : pc;
        beat_addr       = head.addr + (32'(beat_cnt) << OFF_W);
        write_fifo      = rst_n && r_fire && (drop_cnt == '0) && !jump;
    end

    always_comb begin
        fetch_instr_pc = '0;
        slot_valid     = '0;
        fetch_err      = 1'b0;
        if (write_fifo) begin
            slot_valid = (beat_cnt == '0) ? head.mask : '1;
            fetch_err  = (rresp != 2'b00);
            for (int i = 0; i < NSLOT; i++) begin
                fetch_instr_pc[64*i +: 64] = {rdata[32*i +: 32], beat_addr + 32'(4 * i)};
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            arvalid     <= 1'b0;
            araddr      <= '0;
            arlen       <= '0;
            ar_mask     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            beat_cnt    <= '0;
        end else begin
            // pc is the next address not yet placed on AR; it advances when AR is loaded.
            if (ar_hold) begin
                pc <= src_pc;
            end else if (ar_load) begin
                arvalid <= 1'b1;
                araddr  <= src_pc & ~BEAT_MASK;
                arlen   <= calc_arlen(src_pc);
                ar_mask <= calc_mask(src_pc);
                pc      <= next_block(src_pc);
            end else begin
                arvalid <= 1'b0;
                pc      <= src_pc;
            end

            if (ar_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (r_last_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            outstanding <= outstanding_nxt;

            if (r_last_fire) begin
                beat_cnt <= '0;
            end else if (r_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            // Everything requested before the jump (accepted or still on AR) is stale.
            if (jump) begin
                drop_cnt <= outstanding + CNT_W'(arvalid) - CNT_W'(r_last_fire);
            end else if (r_last_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // NOTE: the request storage has no reset; entries are only read between a push and
    // its pop, and the pointers that qualify them are reset.
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            req_q[wr_ptr] <= '{addr: araddr, mask: ar_mask};
        end
    end

endmodule

// File: tb/tb_fetch_burst_controller.sv
// Directed bench for fetch_burst_controller: three instances (MAX_OUTSTANDING 2, 3, 1)
// share stimulus; only the selected one is out of reset and observed.
module tb_fetch_burst_controller;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    int           sel;
    logic         arready;
    logic         rvalid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         jump;
    logic [31:0]  jump_addr;
    logic         fifo_full;

    logic         rst_n_v      [3];
    logic [31:0]  araddr_v     [3];
    logic         arvalid_v    [3];
    logic [7:0]   arlen_v      [3];
    logic [2:0]   arsize_v     [3];
    logic [1:0]   arburst_v    [3];
    logic         rready_v     [3];
    logic         write_fifo_v [3];
    logic [127:0] fip_v        [3];
    logic [1:0]   slot_valid_v [3];
    logic         fetch_err_v  [3];

    logic [31:0]  araddr;
    logic         arvalid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rready;
    logic         write_fifo;
    logic [127:0] fetch_instr_pc;
    logic [1:0]   slot_valid;
    logic         fetch_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned MO = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
        assign rst_n_v[g] = rst_n && (sel == g);
        fetch_burst_controller #(
            .DATA_W(64), .BURST_LEN(4), .MAX_OUTSTANDING(MO), .RESET_PC(32'h0)
        ) u_dut (
            .clk(clk), .rst_n(rst_n_v[g]),
            .araddr(araddr_v[g]), .arvalid(arvalid_v[g]), .arready(arready),
            .arlen(arlen_v[g]), .arsize(arsize_v[g]), .arburst(arburst_v[g]),
            .rvalid(rvalid), .rready(rready_v[g]), .rdata(rdata), .rresp(rresp),
            .rlast(rlast), .jump(jump), .jump_addr(jump_addr), .fifo_full(fifo_full),
            .write_fifo(write_fifo_v[g]), .fetch_instr_pc(fip_v[g]),
            .slot_valid(slot_valid_v[g]), .fetch_err(fetch_err_v[g])
        );
    end

    assign araddr         = araddr_v[sel];
    assign arvalid        = arvalid_v[sel];
    assign arlen          = arlen_v[sel];
    assign arsize         = arsize_v[sel];
    assign arburst        = arburst_v[sel];
    assign rready         = rready_v[sel];
    assign write_fifo     = write_fifo_v[sel];
    assign fetch_instr_pc = fip_v[sel];
    assign slot_valid     = slot_valid_v[sel];
    assign fetch_err      = fetch_err_v[sel];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a);
        return {(a + 32'd4) ^ KEY, a ^ KEY};
    endfunction

    // Called just after a negedge; waits for arvalid, checks it, handshakes once.
    task automatic take_ar(input string tag, input logic [31:0] a, input logic [7:0] len);
        int n;
        n = 0;
        arready = 1'b1;
        #1;
        while (!arvalid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, arvalid, 1'b1);
        check({tag, "_addr"}, araddr, a);
        check({tag, "_len"}, arlen, len);
        @(negedge clk);
        arready = 1'b0;
    endtask

    // Presents one R beat for the block address a and handshakes it.
    task automatic send_beat(input string tag, input logic [31:0] a, input logic last,
                             input logic [1:0] resp, input logic exp_wr,
                             input logic [1:0] exp_mask);
        int n;
        n = 0;
        rvalid = 1'b1;
        rdata  = beat_data(a);
        rlast  = last;
        rresp  = resp;
        #1;
        while (!rready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_rdy"}, rready, 1'b1);
        check({tag, "_wr"}, write_fifo, exp_wr);
        if (exp_wr) begin
            check({tag, "_mask"}, slot_valid, exp_mask);
            check({tag, "_err"}, fetch_err, resp != 2'b00);
            check({tag, "_slot0"}, fetch_instr_pc[63:0], {a ^ KEY, a});
            check({tag, "_slot1"}, fetch_instr_pc[127:64], {(a + 32'd4) ^ KEY, a + 32'd4});
        end
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic reset_into(input int s);
        sel   = s;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        jump      = 1'b0;
        jump_addr = '0;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_wr", write_fifo, 1'b0);
        check("rst_mask", slot_valid, 2'b00);
        check("rst_err", fetch_err, 1'b0);
        check("rst_fip_lo", fetch_instr_pc[63:0], 64'h0);
        check("rst_fip_hi", fetch_instr_pc[127:64], 64'h0);
        check("arburst", arburst, 2'b01);
        check("arsize", arsize, 3'd3);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_arvalid", arvalid, 1'b0);

        // Two blocks in flight, then the limit holds off a third.
        take_ar("ar1", 32'h0, 8'd3);
        take_ar("ar2", 32'h20, 8'd3);
        arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("no_ar3", arvalid, 1'b0);
            @(negedge clk);
        end
        arready = 1'b0;
        for (int b = 0; b < 4; b++) send_beat("b1", 32'(8 * b), b == 3, 2'b00, 1'b1, 2'b11);
        take_ar("ar3", 32'h40, 8'd3);

        // FIFO backpressure mid-burst.
        send_beat("b2", 32'h20, 1'b0, 2'b00, 1'b1, 2'b11);
        send_beat("b2", 32'h28, 1'b0, 2'b00, 1'b1, 2'b11);
        rvalid    = 1'b1;
        rdata     = beat_data(32'h30);
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_rready", rready, 1'b0);
            check("full_wr", write_fifo, 1'b0);
            @(negedge clk);
        end
        fifo_full = 1'b0;
        send_beat("b2", 32'h30, 1'b0, 2'b00, 1'b1, 2'b11);
        send_beat("b2", 32'h38, 1'b1, 2'b00, 1'b1, 2'b11);
        take_ar("ar4", 32'h60, 8'd3);

        // Error response on beat 2 only.
        send_beat("b3", 32'h40, 1'b0, 2'b00, 1'b1, 2'b11);
        send_beat("b3", 32'h48, 1'b0, 2'b00, 1'b1, 2'b11);
        send_beat("b3e", 32'h50, 1'b0, 2'b10, 1'b1, 2'b11);
        send_beat("b3", 32'h58, 1'b1, 2'b00, 1'b1, 2'b11);

        // Reset in the middle of a burst.
        send_beat("b4", 32'h60, 1'b0, 2'b00, 1'b1, 2'b11);
        rst_n  = 1'b0;
        rvalid = 1'b1;
        rdata  = beat_data(32'h68);
        @(negedge clk);
        #1;
        check("mid_rst_arvalid", arvalid, 1'b0);
        check("mid_rst_wr", write_fifo, 1'b0);
        check("mid_rst_mask", slot_valid, 2'b00);
        check("mid_rst_err", fetch_err, 1'b0);
        check("mid_rst_fip_lo", fetch_instr_pc[63:0], 64'h0);
        check("mid_rst_fip_hi", fetch_instr_pc[127:64], 64'h0);

        // Jump straight out of reset with nothing in flight; stray beat is ignored.
        rst_n     = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'h10C;
        #1;
        check("stray_rready", rready, 1'b1);
        check("stray_wr", write_fifo, 1'b0);
        @(negedge clk);
        jump   = 1'b0;
        rvalid = 1'b0;
        take_ar("jmp", 32'h108, 8'd2);
        take_ar("jmp_next", 32'h120, 8'd3);
        send_beat("jb", 32'h108, 1'b0, 2'b00, 1'b1, 2'b10);
        send_beat("jb", 32'h110, 1'b0, 2'b00, 1'b1, 2'b11);
        send_beat("jb", 32'h118, 1'b1, 2'b00, 1'b1, 2'b11);

        // Jump with two accepted requests and a third stalled on AR.
        reset_into(1);
        take_ar("s_ar1", 32'h0, 8'd3);
        take_ar("s_ar2", 32'h20, 8'd3);
        jump      = 1'b1;
        jump_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", arvalid, 1'b1);
            check("stall_addr", araddr, 32'h40);
            check("stall_len", arlen, 8'd3);
            @(negedge clk);
            jump = 1'b0;
        end
        take_ar("stall_fire", 32'h40, 8'd3);
        fifo_full = 1'b1;
        for (int b = 0; b < 12; b++) send_beat("drop", 32'(8 * b), (b % 4) == 3, 2'b00, 1'b0, 2'b00);
        fifo_full = 1'b0;
        take_ar("post_jump", 32'h200, 8'd3);
        send_beat("pj", 32'h200, 1'b0, 2'b00, 1'b1, 2'b11);

        // Jump coinciding with rlast of the only outstanding request.
        reset_into(2);
        take_ar("c_ar1", 32'h0, 8'd3);
        #1;
        check("c_no_ar", arvalid, 1'b0);
        for (int b = 0; b < 3; b++) send_beat("c", 32'(8 * b), 1'b0, 2'b00, 1'b1, 2'b11);
        jump      = 1'b1;
        jump_addr = 32'h400;
        send_beat("c_jlast", 32'h18, 1'b1, 2'b00, 1'b0, 2'b00);
        jump = 1'b0;
        take_ar("c_jmp", 32'h400, 8'd3);
        send_beat("c_new", 32'h400, 1'b0, 2'b00, 1'b1, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
